// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending-machine controller slice:
//   - state_t      : controller FSM states
//   - KEY_*        : bit positions inside the debouncer's flag_key bus
//   - COIN*_VAL    : coin values in 0.5-yuan units
//   - key_act_t / decode_key : reduces a multi-bit key pulse vector to the
//                    single action that will be acted on this cycle
// -----------------------------------------------------------------------------
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_REFUND   = 2'd3
    } state_t;

    localparam int KEY_COIN05  = 0;
    localparam int KEY_COIN1   = 1;
    localparam int KEY_CONFIRM = 2;
    localparam int KEY_CANCEL  = 3;

    localparam int COIN05_VAL = 1;
    localparam int COIN1_VAL  = 2;

    typedef enum logic [2:0] {
        ACT_NONE    = 3'd0,
        ACT_COIN05  = 3'd1,
        ACT_COIN1   = 3'd2,
        ACT_CONFIRM = 3'd3,
        ACT_CANCEL  = 3'd4
    } key_act_t;

    // Only the highest-priority pressed key survives; the rest are dropped.
    // Priority: cancel > confirm > coin1 > coin05.
    function automatic key_act_t decode_key(input logic [3:0] flags);
        key_act_t act;
        act = ACT_NONE;
        if (flags[KEY_CANCEL]) begin
            act = ACT_CANCEL;
        end else if (flags[KEY_CONFIRM]) begin
            act = ACT_CONFIRM;
        end else if (flags[KEY_COIN1]) begin
            act = ACT_COIN1;
        end else if (flags[KEY_COIN05]) begin
            act = ACT_COIN05;
        end
        return act;
    endfunction

endpackage

// File: rtl/vend_ctrl_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// Fixed-length hold interval generator, shared with the display stage.
//   clk    : clock
//   srst   : synchronous active-high reset (aborts any running interval)
//   start  : one-cycle pulse; the interval begins on the following cycle
//   active : high for exactly HOLD_CYCLES cycles after start
//   done   : high during the last active cycle (counter == HOLD_CYCLES-1),
//            so a consumer can leave its hold state on the same edge that
//            active drops
// The counter sits at 0 whenever the timer is idle.
// -----------------------------------------------------------------------------
module hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic srst,
    input  logic start,
    output logic active,
    output logic done
);

    // A 1-cycle hold still needs a 1-bit counter.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             active_q;
    logic             active_d;
    logic             done_w;

    assign done_w = active_q && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            // A restart while active re-arms the full interval.
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (done_w) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (active_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign done   = done_w;

endmodule

// File: rtl/vend_ctrl.sv
// -----------------------------------------------------------------------------
// vend_ctrl
// Vending-machine transaction controller fed by the key debouncer.
//   sclk        : system clock (50 MHz)
//   rst         : synchronous active-high reset; aborts any transaction
//   flag_key    : one-cycle key pulses {cancel, confirm, coin1, coin05}
//   balance     : current credit, 0.5-yuan units
//   change      : change/refund amount, valid while dispense or refund
//   dispense    : high HOLD_CYCLES cycles after a successful purchase
//   refund      : high HOLD_CYCLES cycles after a cancel
//   coin_reject : one-cycle pulse when a coin would exceed MAX_BAL
//   short_pay   : one-cycle pulse on confirm with insufficient credit
//   busy        : high while dispensing or refunding
// Every output is a flop; each response shows up one clock after the key
// pulse is sampled.
// -----------------------------------------------------------------------------
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE       = 5,
    parameter int MAX_BAL     = 15,
    parameter int BAL_W       = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [3:0]       flag_key,
    output logic [BAL_W-1:0] balance,
    output logic [BAL_W-1:0] change,
    output logic             dispense,
    output logic             refund,
    output logic             coin_reject,
    output logic             short_pay,
    output logic             busy
);

    localparam logic [BAL_W-1:0] PRICE_B  = BAL_W'(PRICE);
    // Credit arithmetic runs one bit wider so balance + coin cannot wrap.
    localparam logic [BAL_W:0]   MAX_BAL_W = (BAL_W + 1)'(MAX_BAL);
    localparam logic [BAL_W:0]   C05_W     = (BAL_W + 1)'(COIN05_VAL);
    localparam logic [BAL_W:0]   C1_W      = (BAL_W + 1)'(COIN1_VAL);

    state_t           state_q,       state_d;
    logic [BAL_W-1:0] balance_q,     balance_d;
    logic [BAL_W-1:0] change_q,      change_d;
    logic             dispense_q,    dispense_d;
    logic             refund_q,      refund_d;
    logic             coin_reject_q, coin_reject_d;
    logic             short_pay_q,   short_pay_d;
    logic             busy_q,        busy_d;

    key_act_t         key_act;
    logic [BAL_W:0]   coin_val;
    logic [BAL_W:0]   coin_sum;
    logic             timer_start;
    logic             timer_active;
    logic             timer_done;

    assign key_act  = decode_key(flag_key);
    assign coin_val = (key_act == ACT_COIN1) ? C1_W : C05_W;
    assign coin_sum = {1'b0, balance_q} + coin_val;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (sclk),
        .srst   (rst),
        .start  (timer_start),
        .active (timer_active),
        .done   (timer_done)
    );

    always_comb begin
        state_d       = state_q;
        balance_d     = balance_q;
        change_d      = change_q;
        dispense_d    = dispense_q;
        refund_d      = refund_q;
        busy_d        = busy_q;
        coin_reject_d = 1'b0;
        short_pay_d   = 1'b0;
        timer_start   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                unique case (key_act)
                    ACT_CANCEL: begin
                        // Nothing to hand back when idle.
                        if (state_q == ST_ACCUM) begin
                            change_d    = balance_q;
                            balance_d   = '0;
                            refund_d    = 1'b1;
                            busy_d      = 1'b1;
                            state_d     = ST_REFUND;
                            timer_start = 1'b1;
                        end
                    end
                    ACT_CONFIRM: begin
                        if ((state_q == ST_ACCUM) && (balance_q >= PRICE_B)) begin
                            // Exact payment (zero change) still dispenses.
                            change_d    = balance_q - PRICE_B;
                            balance_d   = '0;
                            dispense_d  = 1'b1;
                            busy_d      = 1'b1;
                            state_d     = ST_DISPENSE;
                            timer_start = 1'b1;
                        end else begin
                            short_pay_d = 1'b1;
                        end
                    end
                    ACT_COIN1, ACT_COIN05: begin
                        if (coin_sum > MAX_BAL_W) begin
                            coin_reject_d = 1'b1;
                        end else begin
                            balance_d = coin_sum[BAL_W-1:0];
                            state_d   = ST_ACCUM;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            ST_DISPENSE, ST_REFUND: begin
                // Keys are deliberately deaf for the entire hold, including
                // the cycle in which the timer finishes.
                if (timer_done) begin
                    dispense_d = 1'b0;
                    refund_d   = 1'b0;
                    change_d   = '0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            balance_q     <= '0;
            change_q      <= '0;
            dispense_q    <= 1'b0;
            refund_q      <= 1'b0;
            coin_reject_q <= 1'b0;
            short_pay_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            balance_q     <= balance_d;
            change_q      <= change_d;
            dispense_q    <= dispense_d;
            refund_q      <= refund_d;
            coin_reject_q <= coin_reject_d;
            short_pay_q   <= short_pay_d;
            busy_q        <= busy_d;
        end
    end

    assign balance     = balance_q;
    assign change      = change_q;
    assign dispense    = dispense_q;
    assign refund      = refund_q;
    assign coin_reject = coin_reject_q;
    assign short_pay   = short_pay_q;
    assign busy        = busy_q;

    // The timer and the busy flag must always agree; a divergence would mean
    // the FSM and the hold interval lost step.
    logic unused_active;
    assign unused_active = timer_active ^ busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_ctrl
// Directed bench for vend_ctrl with HOLD_CYCLES=8, PRICE=5. Each step pushes
// the expected output vector onto a scoreboard queue, applies one clock, then
// pops and compares every output field.
// -----------------------------------------------------------------------------
module tb_vend_ctrl;

    localparam int HOLD = 8;

    typedef struct packed {
        logic [3:0] bal;
        logic [3:0] chg;
        logic       disp;
        logic       rfd;
        logic       rej;
        logic       sp;
        logic       bsy;
    } exp_t;

    logic       sclk;
    logic       rst;
    logic [3:0] flag_key;
    logic [3:0] balance;
    logic [3:0] change;
    logic       dispense;
    logic       refund;
    logic       coin_reject;
    logic       short_pay;
    logic       busy;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    int   step_no;

    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_C05  = 4'b0001;
    localparam logic [3:0] K_C1   = 4'b0010;
    localparam logic [3:0] K_CONF = 4'b0100;
    localparam logic [3:0] K_CANC = 4'b1000;

    vend_ctrl #(
        .PRICE       (5),
        .MAX_BAL     (15),
        .BAL_W       (4),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .sclk        (sclk),
        .rst         (rst),
        .flag_key    (flag_key),
        .balance     (balance),
        .change      (change),
        .dispense    (dispense),
        .refund      (refund),
        .coin_reject (coin_reject),
        .short_pay   (short_pay),
        .busy        (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    function automatic exp_t e(input int bal, input int chg, input logic d,
                               input logic r, input logic rej, input logic sp,
                               input logic bsy);
        exp_t x;
        x.bal  = 4'(bal);
        x.chg  = 4'(chg);
        x.disp = d;
        x.rfd  = r;
        x.rej  = rej;
        x.sp   = sp;
        x.bsy  = bsy;
        return x;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL step %0d %s: observed %0d expected %0d", step_no, tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, then check the registered response.
    task automatic cyc(input logic r, input logic [3:0] k, input exp_t x);
        exp_t got;
        sb.push_back(x);
        rst      = r;
        flag_key = k;
        @(posedge sclk);
        #1;
        rst      = 1'b0;
        flag_key = K_NONE;
        step_no++;
        got = sb.pop_front();
        chk("balance",     int'(balance),     int'(got.bal));
        chk("change",      int'(change),      int'(got.chg));
        chk("dispense",    int'(dispense),    int'(got.disp));
        chk("refund",      int'(refund),      int'(got.rfd));
        chk("coin_reject", int'(coin_reject), int'(got.rej));
        chk("short_pay",   int'(short_pay),   int'(got.sp));
        chk("busy",        int'(busy),        int'(got.bsy));
        $display("[TB] step %0d rst=%0b key=%4b bal=%0d chg=%0d disp=%0b ref=%0b rej=%0b sp=%0b busy=%0b",
                 step_no, r, k, balance, change, dispense, refund, coin_reject, short_pay, busy);
    endtask

    // Remaining hold cycles after the first one, optional key noise, then idle.
    task automatic hold_rest(input int chg, input logic d, input logic [3:0] k);
        for (int i = 0; i < HOLD - 1; i++) begin
            cyc(1'b0, k, e(0, chg, d, ~d, 0, 0, 1));
        end
        cyc(1'b0, k, e(0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        step_no  = 0;
        rst      = 1'b1;
        flag_key = K_NONE;
        @(posedge sclk);
        #1;

        // Reset state, with a coin pulse that must be discarded under reset.
        cyc(1'b1, K_C1, e(0, 0, 0, 0, 0, 0, 0));

        // Exact payment: 2, 4, 5 then confirm with zero change.
        cyc(1'b0, K_C1,   e(2, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_C1,   e(4, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_C05,  e(5, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_CONF, e(0, 0, 1, 0, 0, 0, 1));
        hold_rest(0, 1'b1, K_NONE);

        // Overpay: balance 6, change 1; key on first idle cycle is processed.
        cyc(1'b0, K_C1,   e(2, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_C1,   e(4, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_C1,   e(6, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_CONF, e(0, 1, 1, 0, 0, 0, 1));
        hold_rest(1, 1'b1, K_NONE);

        // Confirm and cancel in IDLE.
        cyc(1'b0, K_CONF, e(0, 0, 0, 0, 0, 1, 0));
        cyc(1'b0, K_CANC, e(0, 0, 0, 0, 0, 0, 0));

        // Short pay, then cancel refunds 2.
        cyc(1'b0, K_C1,   e(2, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_CONF, e(2, 0, 0, 0, 0, 1, 0));
        cyc(1'b0, K_NONE, e(2, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_CANC, e(0, 2, 0, 1, 0, 0, 1));
        hold_rest(2, 1'b0, K_NONE);

        // Fill to 14, reject coin1, accept coin05 to 15, reject coin05 at 15.
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b0, K_C1, e(2 * i, 0, 0, 0, 0, 0, 0));
        end
        cyc(1'b0, K_C1,  e(14, 0, 0, 0, 1, 0, 0));
        cyc(1'b0, K_C05, e(15, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_C05, e(15, 0, 0, 0, 1, 0, 0));
        // Refund 15 with coins hammered throughout the hold (all ignored).
        cyc(1'b0, K_CANC, e(0, 15, 0, 1, 0, 0, 1));
        hold_rest(15, 1'b0, K_C1 | K_C05);

        // All keys at once: cancel wins.
        cyc(1'b0, K_C1, e(2, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_C1, e(4, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_C1, e(6, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, 4'b1111, e(0, 6, 0, 1, 0, 0, 1));
        hold_rest(6, 1'b0, K_NONE);

        // Confirm plus coins: confirm wins over coins (short pay at balance 0).
        cyc(1'b0, K_CONF | K_C1, e(0, 0, 0, 0, 0, 1, 0));

        // Coins during dispense ignored, then reset on hold cycle 3.
        cyc(1'b0, K_C1,   e(2, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_C1,   e(4, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_C1,   e(6, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_CONF, e(0, 1, 1, 0, 0, 0, 1));
        cyc(1'b0, K_C1,   e(0, 1, 1, 0, 0, 0, 1));
        cyc(1'b0, K_C05,  e(0, 1, 1, 0, 0, 0, 1));
        cyc(1'b1, K_C1,   e(0, 0, 0, 0, 0, 0, 0));
        // After reset the machine is idle and the hold timer restarts clean.
        cyc(1'b0, K_C05,  e(1, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, K_CANC, e(0, 1, 0, 1, 0, 0, 1));
        hold_rest(1, 1'b0, K_NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
